// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds datapath widths, the bubble encoding, fetch FSM state encodings,
// the IF/ID payload struct and a PC alignment helper.
package instr_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // addi x0,x0,0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [ILEN-1:0] instr;
    } if_id_t;

    // Instructions are word aligned; only the two low PC bits matter.
    function automatic logic pc_aligned(input logic [1:0] pc_lo);
        return pc_lo == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response channel.
//   req_valid/req_addr/req_ready : one request per accepted handshake
//   rsp_valid/rsp_data           : one in-order response per accepted request
// master = fetch stage, slave = instruction memory.
interface instr_fetch_stage_if;
    import instr_fetch_stage_pkg::*;

    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/instr_fetch_stage_if_id.sv
// IF/ID pipeline register: load, hold on decode stall, otherwise bubble.
// Flush forces a bubble even while decode is stalled. Bubbles keep the pc fields.
// Ports:
//   clk, reset         clock, async active-high reset
//   flush              squash the register contents
//   load               capture load_pc/load_instr this cycle
//   stall_id           decode stalled; hold contents
//   load_pc/load_instr instruction being delivered
//   if_id              registered IF/ID payload
module instr_fetch_stage_if_id
    import instr_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic            stall_id,
    input  logic [XLEN-1:0] load_pc,
    input  logic [ILEN-1:0] load_instr,
    output if_id_t          if_id
);

    localparam if_id_t IF_ID_RST = '{
        valid:    1'b0,
        pc:       '0,
        pc_plus4: XLEN'(4),
        instr:    NOP_INSTR
    };

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Next-state: flush > load > stall hold > bubble
    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (load) begin
            if_id_d.valid    = 1'b1;
            if_id_d.pc       = load_pc;
            if_id_d.pc_plus4 = load_pc + XLEN'(4);
            if_id_d.instr    = load_instr;
        end else if (!stall_id) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_q <= IF_ID_RST;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id = if_id_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: issues one instruction-memory request per PC, absorbs decode
// stalls in a one-entry hold buffer, discards stale responses after a flush,
// and flags misaligned PCs or response timeouts as a sticky fault.
// Ports:
//   clk, reset        clock, async active-high reset
//   pc                current PC from the program counter
//   stall_id, flush   decode stall / taken branch-jump squash
//   imem              instruction-memory channel (master side)
//   stall_pc          1 = program counter must hold
//   if_id_*           IF/ID pipeline register outputs
//   fetch_fault       sticky misalignment/timeout flag, cleared by flush
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       pc,
    input  logic                  stall_id,
    input  logic                  flush,
    instr_fetch_stage_if.master   imem,
    output logic                  stall_pc,
    output logic                  if_id_valid,
    output logic [XLEN-1:0]       if_id_pc,
    output logic [XLEN-1:0]       if_id_pc_plus4,
    output logic [ILEN-1:0]       if_id_instr,
    output logic                  fetch_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [ILEN-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;

    logic            req_valid_c;
    logic            hs_c;
    logic            load_c;
    logic [ILEN-1:0] load_instr_c;
    logic            counting_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic            timeout_c;
    if_id_t          if_id;

    // Requests only from REQ, with an aligned PC and no pending fault
    assign req_valid_c = (state_q == FS_REQ) && pc_aligned(pc[1:0]) && !fault_q;
    assign hs_c        = req_valid_c && imem.req_ready;
    assign counting_c  = ((state_q == FS_WAIT) || (state_q == FS_DRAIN)) && !imem.rsp_valid;
    assign cnt_inc_c   = cnt_q + CNT_W'(1);
    assign timeout_c   = counting_c && (cnt_inc_c == CNT_W'(TIMEOUT));

    // Fetch FSM next-state; flush overrides the normal transitions
    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        hold_d       = hold_q;
        fault_d      = fault_q;
        load_c       = 1'b0;
        load_instr_c = imem.rsp_data;

        case (state_q)
            FS_REQ: begin
                if (!pc_aligned(pc[1:0])) begin
                    fault_d = 1'b1;
                end
                if (hs_c) begin
                    req_pc_d = pc;
                    state_d  = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem.rsp_valid) begin
                    if (!stall_id) begin
                        load_c  = 1'b1;
                        state_d = FS_REQ;
                    end else begin
                        hold_d  = imem.rsp_data;
                        state_d = FS_HOLD;
                    end
                end else if (timeout_c) begin
                    fault_d = 1'b1;
                    state_d = FS_REQ;
                end
            end
            FS_HOLD: begin
                if (!stall_id) begin
                    load_c       = 1'b1;
                    load_instr_c = hold_q;
                    state_d      = FS_REQ;
                end
            end
            FS_DRAIN: begin
                if (imem.rsp_valid) begin
                    state_d = FS_REQ;
                end else if (timeout_c) begin
                    fault_d = 1'b1;
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase

        // A request accepted or still in flight during a flush must be drained
        if (flush) begin
            fault_d = 1'b0;
            load_c  = 1'b0;
            case (state_q)
                FS_REQ:   state_d = hs_c ? FS_DRAIN : FS_REQ;
                FS_WAIT:  state_d = imem.rsp_valid ? FS_REQ : FS_DRAIN;
                FS_HOLD:  state_d = FS_REQ;
                FS_DRAIN: state_d = imem.rsp_valid ? FS_REQ : FS_DRAIN;
                default:  state_d = FS_REQ;
            endcase
        end

        // Counter restarts on any state change and on flush
        cnt_d = '0;
        if (!flush && counting_c && (state_d == state_q)) begin
            cnt_d = cnt_inc_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FS_REQ;
            req_pc_q <= '0;
            hold_q   <= NOP_INSTR;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
        end
    end

    instr_fetch_stage_if_id u_if_id (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .load       (load_c),
        .stall_id   (stall_id),
        .load_pc    (req_pc_q),
        .load_instr (load_instr_c),
        .if_id      (if_id)
    );

    // PC advances only when an instruction is delivered or on a redirect
    assign stall_pc       = !(load_c || flush);
    assign imem.req_valid = req_valid_c;
    assign imem.req_addr  = pc;

    assign if_id_valid    = if_id.valid;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_instr    = if_id.instr;
    assign fetch_fault    = fault_q;

endmodule
